// File: rtl/cache_pkg.sv
// Shared constants for the direct-mapped write-through data cache:
// default geometry and controller state encoding.
package cache_pkg;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;
    localparam int INDEX_W  = 5;
    localparam int OFFSET_W = 2;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_REFILL     = 2'd1;
    localparam logic [1:0] S_WRITE_THRU = 2'd2;

endpackage

// File: rtl/dcache_array.sv
// Tag, valid and data storage for the data cache.
// Reads are combinational by index; all writes are synchronous.
// Only the valid bits are cleared by reset; tag and data contents survive.
module dcache_array
    import cache_pkg::*;
#(
    parameter int DATA_W   = cache_pkg::DATA_W,
    parameter int INDEX_W  = cache_pkg::INDEX_W,
    parameter int OFFSET_W = cache_pkg::OFFSET_W,
    parameter int TAG_W    = cache_pkg::TAG_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INDEX_W-1:0]  index,
    input  logic [OFFSET_W-1:0] rd_offset,
    output logic [TAG_W-1:0]    tag_out,
    output logic                valid_out,
    output logic [DATA_W-1:0]   rdata_out,
    input  logic                fill_en,
    input  logic [OFFSET_W-1:0] fill_offset,
    input  logic [DATA_W-1:0]   fill_data,
    input  logic                set_en,
    input  logic [TAG_W-1:0]    set_tag,
    input  logic                store_en,
    input  logic [OFFSET_W-1:0] store_offset,
    input  logic [DATA_W-1:0]   store_data
);

    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFSET_W;

    logic [DATA_W-1:0] data_mem [LINES][WORDS];
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]  valid;

    assign tag_out   = tag_mem[index];
    assign valid_out = valid[index];
    assign rdata_out = data_mem[index][rd_offset];

    // Data words: refill writes and store-hit updates (never in the same cycle).
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_mem[index][fill_offset] <= fill_data;
        end
        if (store_en) begin
            data_mem[index][store_offset] <= store_data;
        end
    end

    // Tag is written together with the valid bit when a refill completes.
    always_ff @(posedge clk) begin
        if (set_en) begin
            tag_mem[index] <= set_tag;
        end
    end

    // Valid bits: cleared by reset, set only on the last refill word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (set_en) begin
            valid[index] <= 1'b1;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data-cache controller.
// Read hits return data in the same cycle; read misses refill a 4-word line
// from word-addressed main memory; every store is written through to memory.
// Optional macro DCACHE_STATS_EN adds saturating hit_count / miss_count outputs.
//
// state        | meaning
// S_IDLE       | accept requests; hits served combinationally
// S_REFILL     | fetching the missed line word by word, stall held
// S_WRITE_THRU | waiting for main memory to accept a store, stall held
module dcache_controller
    import cache_pkg::*;
#(
    parameter int ADDR_W   = cache_pkg::ADDR_W,
    parameter int DATA_W   = cache_pkg::DATA_W,
    parameter int INDEX_W  = cache_pkg::INDEX_W,
    parameter int OFFSET_W = cache_pkg::OFFSET_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef DCACHE_STATS_EN
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
`endif
    input  logic              mem_ready
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    logic [1:0]          state;
    logic [OFFSET_W-1:0] cnt;

    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;

    logic [TAG_W-1:0]    line_tag;
    logic                line_valid;
    logic [DATA_W-1:0]   line_word;
    logic                hit;

    logic                fill_en;
    logic                set_en;
    logic                store_en;

    assign tag    = cpu_addr[ADDR_W-1 -: TAG_W];
    assign index  = cpu_addr[OFFSET_W +: INDEX_W];
    assign offset = cpu_addr[OFFSET_W-1:0];

    assign hit = line_valid && (line_tag == tag);

    // The address is held while stalled, so the CPU index also addresses refills.
    assign fill_en  = rst_n && (state == S_REFILL) && mem_ready;
    assign set_en   = fill_en && (&cnt);
    assign store_en = rst_n && (state == S_WRITE_THRU) && mem_ready && hit;

    dcache_array #(
        .DATA_W   (DATA_W),
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W),
        .TAG_W    (TAG_W)
    ) u_array (
        .clk          (clk),
        .rst_n        (rst_n),
        .index        (index),
        .rd_offset    (offset),
        .tag_out      (line_tag),
        .valid_out    (line_valid),
        .rdata_out    (line_word),
        .fill_en      (fill_en),
        .fill_offset  (cnt),
        .fill_data    (mem_rdata),
        .set_en       (set_en),
        .set_tag      (tag),
        .store_en     (store_en),
        .store_offset (offset),
        .store_data   (cpu_wdata)
    );

    // Stall and load data are combinational so a miss freezes the pipe this cycle.
    always_comb begin
        cpu_stall = 1'b0;
        cpu_rdata = '0;
        if (rst_n) begin
            cpu_rdata = line_word;
            if (state == S_IDLE) begin
                cpu_stall = cpu_write || (cpu_read && !hit);
            end else begin
                cpu_stall = 1'b1;
            end
        end
    end

    // Controller FSM with registered memory-side request, address and data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_write) begin
                        state      <= S_WRITE_THRU;
                        mem_wr_req <= 1'b1;
                        mem_addr   <= cpu_addr;
                        mem_wdata  <= cpu_wdata;
                    end else if (cpu_read && !hit) begin
                        state      <= S_REFILL;
                        cnt        <= '0;
                        mem_rd_req <= 1'b1;
                        mem_addr   <= {tag, index, {OFFSET_W{1'b0}}};
                    end
                end
                S_REFILL: begin
                    if (mem_ready) begin
                        cnt <= cnt + 1'b1;
                        if (&cnt) begin
                            mem_rd_req <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            mem_addr[OFFSET_W-1:0] <= cnt + 1'b1;
                        end
                    end
                end
                S_WRITE_THRU: begin
                    if (mem_ready) begin
                        mem_wr_req <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    mem_rd_req <= 1'b0;
                    mem_wr_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic hit_inc;
    logic miss_inc;

    assign hit_inc  = rst_n && (state == S_IDLE) && cpu_read && !cpu_write && hit;
    assign miss_inc = rst_n && (state == S_IDLE) && cpu_read && !cpu_write && !hit;

    // Saturating event counters; a miss is counted once on entry to refill.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_inc && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_inc && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
